// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multiport register file.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_NUM_REGS = 32;
    localparam int REG_AW       = $clog2(DEF_NUM_REGS);

    // LEGv8 XZR lives at the top index in the default configuration.
    localparam int XZR_IDX = DEF_NUM_REGS - 1;

    typedef logic [REG_AW-1:0]     reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] reg_word_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: register-select mux, zero-index masking and
// an optional same-cycle bypass from the write port.
// Bypass is compiled in by the parent when REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int ZERO_IDX  = NUM_REGS - 1,
    parameter bit BYPASS_EN = 1'b0
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
    input  logic [NUM_REGS-1:0]             busy_i,
    input  logic [$clog2(NUM_REGS)-1:0]     rd_addr_i,
    input  logic                            wr_en_i,
    input  logic [$clog2(NUM_REGS)-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0]               wr_data_i,
    input  logic                            rsv_en_i,
    input  logic [$clog2(NUM_REGS)-1:0]     rsv_addr_i,
    output logic [DATA_W-1:0]               rd_data_o,
    output logic                            rd_busy_o
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_IDX);

    logic byp_hit;

    // Select stored or forwarded data; a forwarded write also retires the
    // hazard unless the same register is being re-reserved this cycle.
    always_comb begin
        byp_hit = BYPASS_EN && wr_en_i && (wr_addr_i == rd_addr_i) && (rd_addr_i != ZERO_A);

        if (rd_addr_i == ZERO_A) begin
            rd_data_o = '0;
        end else if (byp_hit) begin
            rd_data_o = wr_data_i;
        end else begin
            rd_data_o = regs_i[rd_addr_i];
        end

        if (byp_hit) begin
            rd_busy_o = rsv_en_i && (rsv_addr_i == rd_addr_i);
        end else begin
            rd_busy_o = busy_i[rd_addr_i];
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file: flop storage, one write port, NUM_RD read ports
// and a per-register busy scoreboard for decode-stage hazard detection.
// Register ZERO_IDX always reads zero and is never marked busy.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ZERO_IDX = NUM_REGS - 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]          wr_addr,
    input  logic [DATA_W-1:0]                    wr_data,
    input  logic                                 rsv_en,
    input  logic [$clog2(NUM_REGS)-1:0]          rsv_addr,
    input  logic [NUM_RD*$clog2(NUM_REGS)-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]             rd_data,
    output logic [NUM_RD-1:0]                    rd_busy,
    output logic [NUM_REGS-1:0]                  busy_vec
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_IDX);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic                            byp_wr_en;
    logic                            byp_rsv_en;

    // Next-state storage: the zero register is never written.
    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != ZERO_A)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Next-state scoreboard: a new reservation supersedes a write-back to the
    // same register, since the new producer has not yet delivered.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rsv_en && (rsv_addr == AW'(i)) && (i != ZERO_IDX)) begin
                busy_d[i] = 1'b1;
            end else if (wr_en && (wr_addr == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // Storage and scoreboard flops; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Forwarding is suppressed while in reset so every output reads zero.
    always_comb begin
        byp_wr_en  = wr_en  && !reset;
        byp_rsv_en = rsv_en && !reset;
    end

    assign busy_vec = busy_q;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        regfile_read_port #(
            .DATA_W    (DATA_W),
            .NUM_REGS  (NUM_REGS),
            .ZERO_IDX  (ZERO_IDX),
            .BYPASS_EN (BYPASS_EN)
        ) u_port (
            .regs_i     (regs_q),
            .busy_i     (busy_q),
            .rd_addr_i  (rd_addr[gi*AW +: AW]),
            .wr_en_i    (byp_wr_en),
            .wr_addr_i  (wr_addr),
            .wr_data_i  (wr_data),
            .rsv_en_i   (byp_rsv_en),
            .rsv_addr_i (rsv_addr),
            .rd_data_o  (rd_data[gi*DATA_W +: DATA_W]),
            .rd_busy_o  (rd_busy[gi])
        );
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: directed scenarios plus randomized traffic
// against an array-based reference model. A second instance covers the
// three-port, 32-bit configuration.
module tb_regfile_multiport;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         rsv_en;
    logic [4:0]   rsv_addr;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;
    logic [1:0]   rd_busy;
    logic [31:0]  busy_vec;

    logic         w2_en;
    logic [4:0]   w2_addr;
    logic [31:0]  w2_data;
    logic         rsv2_en;
    logic [4:0]   rsv2_addr;
    logic [14:0]  r2_addr;
    logic [95:0]  rd2_data;
    logic [2:0]   rd2_busy;
    logic [31:0]  busy2_vec;

    int checks   = 0;
    int failures = 0;

    logic [63:0] m_regs [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    regfile_multiport dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .busy_vec(busy_vec)
    );

    regfile_multiport #(.DATA_W(32), .NUM_RD(3)) dut3 (
        .clk(clk), .reset(reset), .wr_en(w2_en), .wr_addr(w2_addr), .wr_data(w2_data),
        .rsv_en(rsv2_en), .rsv_addr(rsv2_addr), .rd_addr(r2_addr), .rd_data(rd2_data),
        .rd_busy(rd2_busy), .busy_vec(busy2_vec)
    );

    // Expected read data for an address given the current inputs and model.
    function automatic logic [63:0] exp_data(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
        if (BYP && wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    // Expected hazard flag for an address given the current inputs and model.
    function automatic logic exp_busy(input logic [4:0] a);
        if (BYP && wr_en && wr_addr == a && a != 5'd31) return rsv_en && (rsv_addr == a);
        return m_busy[a];
    endfunction

    function automatic logic [31:0] exp_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 64'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        wr_en = 0; rsv_en = 0; w2_en = 0; rsv2_en = 0;
    endtask

    // Advance one clock edge and apply the architectural effect to the model.
    task automatic step();
        @(posedge clk);
        if (!reset) begin
            if (wr_en && wr_addr != 5'd31) m_regs[wr_addr] = wr_data;
            if (wr_en) m_busy[wr_addr] = 1'b0;
            if (rsv_en && rsv_addr != 5'd31) m_busy[rsv_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        wr_addr = 0; wr_data = 0; rsv_addr = 0; rd_addr = 0;
        w2_addr = 0; w2_data = 0; rsv2_addr = 0; r2_addr = 0;
        model_clear();
        step(); step();
        reset = 0;
        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            checks++;
            if (rd_data !== 128'd0 || rd_busy !== 2'b00) begin
                failures++;
                $display("FAIL reset_read addr=%0d data=%h busy=%b required data=0 busy=0", a, rd_data, rd_busy);
            end
        end
        checks++;
        if (busy_vec !== 32'd0) begin
            failures++;
            $display("FAIL reset_busy_vec got=%h required=0", busy_vec);
        end
        $display("reset: registers read zero, busy_vec=%h", busy_vec);
    endtask

    task automatic test_write_read();
        wr_en = 1; wr_addr = 5; wr_data = 64'hDEADBEEF_CAFEF00D;
        step(); idle();
        rd_addr = {5'd5, 5'd5};
        #1;
        checks++;
        if (rd_data[63:0] !== 64'hDEADBEEF_CAFEF00D || rd_data[127:64] !== 64'hDEADBEEF_CAFEF00D) begin
            failures++;
            $display("FAIL write_read_r5 got=%h required=%h on both ports", rd_data, 64'hDEADBEEF_CAFEF00D);
        end
        $display("write r5: p0=%h p1=%h", rd_data[63:0], rd_data[127:64]);
        wr_en = 1; wr_addr = 31; wr_data = 64'h1234;
        step(); idle();
        rd_addr = {5'd31, 5'd31};
        #1;
        checks++;
        if (rd_data !== 128'd0) begin
            failures++;
            $display("FAIL zero_reg_write got=%h required=0", rd_data);
        end
        $display("write r31: p0=%h p1=%h", rd_data[63:0], rd_data[127:64]);
    endtask

    task automatic test_scoreboard();
        rsv_en = 1; rsv_addr = 7;
        step(); idle();
        rd_addr = {5'd0, 5'd7};
        #1;
        checks++;
        if (busy_vec[7] !== 1'b1 || rd_busy !== 2'b01) begin
            failures++;
            $display("FAIL reserve_r7 busy_vec[7]=%b rd_busy=%b required 1 and 01", busy_vec[7], rd_busy);
        end
        $display("reserve r7: busy_vec=%h rd_busy=%b", busy_vec, rd_busy);
        wr_en = 1; wr_addr = 7; wr_data = 64'h77;
        step(); idle();
        #1;
        checks++;
        if (busy_vec[7] !== 1'b0 || rd_busy[0] !== 1'b0 || rd_data[63:0] !== 64'h77) begin
            failures++;
            $display("FAIL writeback_r7 busy=%b rd_busy=%b data=%h required 0 0 77", busy_vec[7], rd_busy[0], rd_data[63:0]);
        end
        $display("writeback r7: busy_vec=%h data=%h", busy_vec, rd_data[63:0]);
        wr_en = 1; wr_addr = 7; wr_data = 64'h78; rsv_en = 1; rsv_addr = 7;
        step(); idle();
        #1;
        checks++;
        if (busy_vec[7] !== 1'b1 || rd_busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL rsv_beats_write busy=%b rd_busy=%b required 1 1", busy_vec[7], rd_busy[0]);
        end
        $display("reserve+write r7: busy_vec=%h", busy_vec);
        rsv_en = 1; rsv_addr = 31;
        step(); idle();
        rd_addr = {5'd31, 5'd31};
        #1;
        checks++;
        if (busy_vec[31] !== 1'b0 || rd_busy !== 2'b00) begin
            failures++;
            $display("FAIL zero_reg_reserve busy=%b rd_busy=%b required 0 00", busy_vec[31], rd_busy);
        end
        $display("reserve r31: busy_vec=%h", busy_vec);
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 3; wr_data = 64'h11;
        step(); idle();
        rsv_en = 1; rsv_addr = 3;
        step(); idle();
        wr_en = 1; wr_addr = 3; wr_data = 64'hAA; rd_addr = {5'd3, 5'd0};
        #1;
        checks++;
        if (rd_data[127:64] !== (BYP ? 64'hAA : 64'h11) || rd_busy[1] !== !BYP || busy_vec[3] !== 1'b1) begin
            failures++;
            $display("FAIL bypass_same_cycle data=%h busy=%b vec3=%b required data=%h busy=%b vec3=1",
                     rd_data[127:64], rd_busy[1], busy_vec[3], BYP ? 64'hAA : 64'h11, !BYP);
        end
        $display("write r3 while reading: p1=%h rd_busy1=%b", rd_data[127:64], rd_busy[1]);
        step(); idle();
        #1;
        checks++;
        if (rd_data[127:64] !== 64'hAA || rd_busy[1] !== 1'b0) begin
            failures++;
            $display("FAIL bypass_next_cycle data=%h busy=%b required AA 0", rd_data[127:64], rd_busy[1]);
        end
        wr_en = 1; wr_addr = 3; wr_data = 64'hBB; rsv_en = 1; rsv_addr = 3;
        #1;
        checks++;
        if (rd_data[127:64] !== exp_data(5'd3) || rd_busy[1] !== exp_busy(5'd3)) begin
            failures++;
            $display("FAIL bypass_with_rsv data=%h busy=%b required %h %b",
                     rd_data[127:64], rd_busy[1], exp_data(5'd3), exp_busy(5'd3));
        end
        step(); idle();
        wr_en = 1; wr_addr = 31; wr_data = 64'h99; rd_addr = {5'd31, 5'd31};
        #1;
        checks++;
        if (rd_data !== 128'd0) begin
            failures++;
            $display("FAIL bypass_zero_reg got=%h required=0", rd_data);
        end
        step(); idle();
        $display("bypass scenario done (bypass=%0d)", BYP);
    endtask

    task automatic test_async_reset();
        wr_en = 1; wr_addr = 5; wr_data = 64'h5555; rsv_en = 1; rsv_addr = 9;
        rd_addr = {5'd5, 5'd7};
        #2;
        reset = 1;
        #1;
        checks++;
        if (rd_data !== 128'd0 || rd_busy !== 2'b00 || busy_vec !== 32'd0) begin
            failures++;
            $display("FAIL async_reset_immediate data=%h busy=%b vec=%h required all 0", rd_data, rd_busy, busy_vec);
        end
        step();
        model_clear();
        checks++;
        if (rd_data !== 128'd0 || rd_busy !== 2'b00 || busy_vec !== 32'd0) begin
            failures++;
            $display("FAIL async_reset_held data=%h busy=%b vec=%h required all 0", rd_data, rd_busy, busy_vec);
        end
        reset = 0; idle();
        step();
        rd_addr = {5'd9, 5'd5};
        #1;
        checks++;
        if (rd_data !== 128'd0 || rd_busy !== 2'b00 || busy_vec !== 32'd0) begin
            failures++;
            $display("FAIL inflight_lost data=%h busy=%b vec=%h required all 0", rd_data, rd_busy, busy_vec);
        end
        $display("async reset: vec=%h data=%h", busy_vec, rd_data);
    endtask

    task automatic test_random();
        logic [4:0] a0, a1;
        for (int n = 0; n < 300; n++) begin
            wr_en    = 1'($urandom);
            wr_addr  = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wr_data  = {$urandom, $urandom};
            rsv_en   = ($urandom % 3) == 0;
            rsv_addr = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            a0       = ($urandom % 4 == 0) ? wr_addr : 5'($urandom_range(0, 7));
            a1       = ($urandom % 4 == 0) ? a0 : 5'($urandom);
            rd_addr  = {a1, a0};
            #1;
            checks++;
            if (rd_data[63:0] !== exp_data(a0) || rd_data[127:64] !== exp_data(a1) ||
                rd_busy !== {exp_busy(a1), exp_busy(a0)} || busy_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random n=%0d a0=%0d a1=%0d data=%h busy=%b vec=%h required data=%h%h busy=%b%b vec=%h",
                         n, a0, a1, rd_data, rd_busy, busy_vec, exp_data(a1), exp_data(a0),
                         exp_busy(a1), exp_busy(a0), exp_vec());
            end
            step();
        end
        idle();
        $display("random: 300 cycles exercised");
    endtask

    task automatic test_wide3();
        w2_en = 1; w2_addr = 0; w2_data = 32'h55;
        step(); idle();
        r2_addr = {5'd0, 5'd0, 5'd0};
        #1;
        checks++;
        if (rd2_data !== {3{32'h55}}) begin
            failures++;
            $display("FAIL three_port_r0 got=%h required=%h", rd2_data, {3{32'h55}});
        end
        $display("3-port r0: %h", rd2_data);
        rsv2_en = 1; rsv2_addr = 30;
        step(); idle();
        r2_addr = {5'd30, 5'd0, 5'd31};
        #1;
        checks++;
        if (busy2_vec !== 32'h4000_0000 || rd2_busy !== 3'b100 || rd2_data !== {32'd0, 32'h55, 32'd0}) begin
            failures++;
            $display("FAIL three_port_busy vec=%h busy=%b data=%h required 40000000 100 %h",
                     busy2_vec, rd2_busy, rd2_data, {32'd0, 32'h55, 32'd0});
        end
        $display("3-port reserve r30: vec=%h busy=%b", busy2_vec, rd2_busy);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_scoreboard();
        test_bypass();
        test_async_reset();
        test_random();
        test_wide3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
